// File: rtl/memory_responder.sv
// Word-addressed RAM responder: one request at a time, WAIT_STATES extra cycles,
// byte-masked stores, registered read data with a one-cycle ready pulse and range fault.
module memory_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        request_i,
  input  logic        store_i,
  input  logic [31:0] memory_access_address_i,
  input  logic [31:0] memory_write_data_i,
  input  logic [3:0]  memory_write_mask_i,
  output logic [31:0] memory_read_data_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        fault_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam logic        START_WAIT = (WAIT_STATES != 0);
  localparam logic [3:0]  WCNT_LOAD  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        store_q, store_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        fault_q, fault_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] idx_s;
  logic          in_range_s;
  logic          mem_we_s;
  logic [31:0]   rd_word_s;

  // Full-width compare so any upper address bit set counts as out of range.
  assign idx_s      = addr_q[AW+1:2];
  assign in_range_s = ({1'b0, addr_q} < ADDR_LIMIT);
  assign rd_word_s  = mem_q[idx_s];
  // Reset on the ACCESS edge suppresses the write entirely.
  assign mem_we_s   = reset_i && (state_q == ST_ACCESS) && store_q && in_range_s;

  assign busy_o             = (state_q != ST_IDLE);
  assign ready_o            = ready_q;
  assign fault_o            = fault_q;
  assign memory_read_data_o = rdata_q;

  // Next-state and output-register computation for the request sequencer.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    store_d = store_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (request_i) begin
          addr_d  = memory_access_address_i;
          wdata_d = memory_write_data_i;
          mask_d  = memory_write_mask_i;
          store_d = store_i;
          if (START_WAIT) begin
            wcnt_d  = WCNT_LOAD;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_ACCESS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d = ST_ACCESS;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_ACCESS: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        if (in_range_s) begin
          fault_d = 1'b0;
          if (!store_q) begin
            rdata_d = rd_word_s;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          fault_d = 1'b1;
          if (!store_q) begin
            rdata_d = 32'd0;
          end else begin
            rdata_d = rdata_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        wcnt_d  = 4'd0;
      end
    endcase
  end

  // Sequencer and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      mask_q  <= 4'd0;
      store_q <= 1'b0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      store_q <= store_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  // Storage array, per-lane write enables; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) begin
          mem_q[idx_s][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/memory_responder.md
# memory_responder

Word-addressed RAM responder that sits on the far side of the core's memory port. It accepts one read or store request at a time, inserts a configurable number of wait states, and applies the core's 4-bit byte write mask on stores. It returns registered read data with a one-cycle `ready` pulse, and flags out-of-range addresses.

## Interface
- `DEPTH_WORDS`, 256, number of 32-bit words; power of two, at least 4.
- `WAIT_STATES`, 1, extra cycles inserted before each access; range 0..15.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  one clock; reset is synchronous and active-low.
- `request`  in  1  access request; sampled only in IDLE.
- `store`  in  1  1 = write, 0 = read; sampled with `request`.
- `memory_access_address`  in  32  byte address; bits [1:0] ignored.
- `memory_write_data`  in  32  store data, already lane-aligned by the core.
- `memory_write_mask`  in  4  byte enables; bit i enables byte lane [8i+7:8i].
- `memory_read_data`  out  32  registered read word.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high whenever the state is not IDLE.
- `fault`  out  1  valid with `ready`; 1 = address out of range.

## Operation
- States are IDLE, WAIT and ACCESS, with a 4-bit wait counter `wcnt`.
- Each operation below happens at the clock edge while in the named state.
- IDLE:
  - If `request`=1, latch address, data, mask and `store`.
  - If `WAIT_STATES`=0 go to ACCESS; otherwise load `wcnt`=`WAIT_STATES`-1 and go to WAIT.
  - If `request`=0, stay in IDLE.
- WAIT:
  - If `wcnt`=0 go to ACCESS; otherwise decrement `wcnt`.
  - Input changes are ignored; only the latched values are used.
- ACCESS: always returns to IDLE. On the same edge:
  - Set `ready`<=1.
  - Word index is address[log2(DEPTH_WORDS)+1:2].
  - Out-of-range condition: latched address >= 4*`DEPTH_WORDS`.
- ACCESS, in range:
  - Store: write only the lanes enabled by the mask; `memory_read_data` holds its previous value.
  - Read: `memory_read_data`<=array word.
  - `fault`<=0.
- ACCESS, out of range:
  - No array write.
  - Read returns 0; a store leaves `memory_read_data` unchanged.
  - `fault`<=1.
- Mask 4'b0000 on a store: array unchanged, normal `ready` pulse.
- `ready` and `fault` clear on the next edge; `fault` is meaningful only while `ready`=1.
- `memory_read_data` holds its value until the next completed in-range read, or a completed out-of-range read.
- No read-during-write forwarding is needed, since only one access is in flight at a time.
- Array contents are not reset and are undefined at power-up.

## Timing
- Request sampled at edge N: `ready` and data are valid in the cycle after edge N+`WAIT_STATES`+1.
  - `WAIT_STATES`=0: 1 cycle after acceptance.
  - `WAIT_STATES`=1: 2 cycles after acceptance.
- Back-to-back: the `ready` cycle is already IDLE, so a request held high during it is accepted at the edge ending it.
  - Peak throughput is one access per `WAIT_STATES`+2 cycles.
- `busy` is combinational from the state: 1 from the cycle after acceptance through the ACCESS cycle; 0 during the `ready` cycle.
- `request` while `busy`=1 is ignored, not queued. The core must hold `request` until it sees `ready`, or re-issue it.
- Reset (`reset`=0 at an edge) forces on that edge:
  - state IDLE, `wcnt`=0;
  - `ready`=0, `fault`=0, `memory_read_data`=0;
  - `busy`=0 in the following cycle.
- Reset mid-operation: if reset is seen at the edge where ACCESS would complete, the write is suppressed. No partial writes occur.
- A request asserted in the same cycle `reset`=0 is not accepted.

## Test plan
- Reset then read:
  - Stimulus: `reset`=0 for 2 cycles; then a read of address 0x10 with word 4 preloaded to 0xDEADBEEF, `WAIT_STATES`=1.
  - Required: all outputs 0 during reset; `ready`=1 with 0xDEADBEEF exactly 2 cycles after acceptance; `busy` high for 2 cycles.
- Masked store:
  - Stimulus: word 2 = 0x11223344; store to 0x08 with data 0xAABBCCDD, mask 4'b0101; then read 0x08.
  - Required: read returns 0x11BB33DD; the store's `ready` pulse leaves `memory_read_data` unchanged.
- Zero wait and back-to-back:
  - Stimulus: `WAIT_STATES`=0; `request` held high for 6 cycles reading 0x0, 0x4 and 0x8.
  - Required: a `ready` pulse every 2 cycles; data is returned in order.
- Out of range:
  - Stimulus: read 0x400 with `DEPTH_WORDS`=256.
  - Required: `ready`=1, `fault`=1, data 0x00000000.
  - Stimulus: store 0x400.
  - Required: `fault`=1; a full dump of the array shows no change.
- Ignored request while busy:
  - Stimulus: `WAIT_STATES`=3; a second `request` pulse with `store`=1 arrives 1 cycle after acceptance.
  - Required: exactly one `ready`; the array is unchanged by the second pulse.
- Reset mid-operation:
  - Stimulus: `WAIT_STATES`=2; store 0xFFFFFFFF to 0x0 (word 0 = 0x0); `reset`=0 on the ACCESS edge.
  - Required: no `ready` pulse; a subsequent read of 0x0 returns 0x00000000.
